// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin owner arbitration of the shared ram1024x32 port, with an optional hold limit.
// Latency: a grant follows req by one cycle from idle, and handover on release costs no bubble cycle.
// Backpressure: requesters keep req high until they see grant; the arbiter revokes a grant (preempted pulse) after MAX_HOLD cycles only if another req is pending.
//
// Ports:
//   clock, reset               system clock (also the RAM clock), synchronous active-high reset
//   req / grant / preempted    per-requester request, one-hot ownership, one-cycle revoke pulse
//   req_address/data/wren      per-requester RAM command, slice i at [i*W +: W]
//   ram_address/data/wren      muxed command to the RAM, driven only from the registered owner
//   ram_q / q                  RAM read data, broadcast unchanged to every requester
module ram_arbiter #(
   parameter int NREQ     = 4,
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = 64
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   output logic [NREQ-1:0]          grant,
   output logic [NREQ-1:0]          preempted,
   input  logic [NREQ*ADDR_W-1:0]   req_address,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   input  logic [NREQ-1:0]          req_wren,
   output logic [ADDR_W-1:0]        ram_address,
   output logic [DATA_W-1:0]        ram_data,
   output logic                     ram_wren,
   input  logic [DATA_W-1:0]        ram_q,
   output logic [DATA_W-1:0]        q
);

   localparam int PTR_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

   typedef enum logic {S_IDLE, S_OWNED} state_t;

   state_t              state_q;
   logic [PTR_W-1:0]    owner_q;
   logic [PTR_W-1:0]    rr_ptr_q;
   logic [HOLD_W-1:0]   hold_cnt_q;
   logic [NREQ-1:0]     grant_q;
   logic [NREQ-1:0]     preempted_q;

   // First set bit of mask at or after start, searching upward mod NREQ.
   // Result is {found, index}. The loop runs downward so the nearest hit is the last assignment.
   function automatic logic [PTR_W:0] pick(input logic [NREQ-1:0] mask,
                                          input logic [PTR_W-1:0] start);
      logic [PTR_W:0] r;
      int             idx;
      r = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(start) + k) % NREQ;
         if (mask[idx]) r = {1'b1, PTR_W'(idx)};
      end
      return r;
   endfunction

   logic [PTR_W-1:0] owner_inc;
   logic [NREQ-1:0]  others;
   logic [PTR_W:0]   pick_idle;
   logic [PTR_W:0]   pick_next;
   logic             hold_at_limit;

   assign owner_inc = (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
   // grant_q is one-hot on the owner while OWNED, so this masks the owner out.
   assign others    = req & ~grant_q;
   assign pick_idle = pick(req, rr_ptr_q);
   // On release req[owner] is already low, so the same search serves release and preempt.
   assign pick_next = pick(others, owner_inc);
   assign hold_at_limit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_W'(HOLD_LAST));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         hold_cnt_q  <= '0;
         grant_q     <= '0;
         preempted_q <= '0;
      end else begin
         preempted_q <= '0;
         case (state_q)
            S_IDLE: begin
               hold_cnt_q <= '0;
               if (pick_idle[PTR_W]) begin
                  state_q <= S_OWNED;
                  owner_q <= pick_idle[PTR_W-1:0];
                  grant_q <= NREQ'(1) << pick_idle[PTR_W-1:0];
               end
            end
            S_OWNED: begin
               if (!req[owner_q]) begin
                  // Release: hand straight to the next requester, or fall idle.
                  rr_ptr_q   <= owner_inc;
                  hold_cnt_q <= '0;
                  if (pick_next[PTR_W]) begin
                     owner_q <= pick_next[PTR_W-1:0];
                     grant_q <= NREQ'(1) << pick_next[PTR_W-1:0];
                  end else begin
                     state_q <= S_IDLE;
                     grant_q <= '0;
                  end
               end else if (hold_at_limit && (|others)) begin
                  // Hold limit reached with a competitor waiting: revoke.
                  preempted_q <= grant_q;
                  rr_ptr_q    <= owner_inc;
                  hold_cnt_q  <= '0;
                  owner_q     <= pick_next[PTR_W-1:0];
                  grant_q     <= NREQ'(1) << pick_next[PTR_W-1:0];
               end else if ((MAX_HOLD != 0) && !hold_at_limit) begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

   // AND-OR mux from the registered one-hot grant; zero when nobody owns the port.
   always_comb begin
      ram_address = '0;
      ram_data    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_q[i]) begin
            ram_address = req_address[i*ADDR_W +: ADDR_W];
            ram_data    = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Gated by the live req so that a release cycle never writes.
   assign ram_wren  = |(grant_q & req & req_wren);
   assign grant     = grant_q;
   assign preempted = preempted_q;
   assign q         = ram_q;

endmodule
